// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage. Computes result and NZCV flags from
// SrcA/SrcB/ALUControl and captures them behind a 2-entry skid buffer
// so that in_ready comes straight from a flop.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
    } op_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, next;
    op_t    m_q, s_q, calc;
    logic   accept, pop;
    logic   load_m_new, load_m_skid, load_s;

    // Shared adder: subtract is A + ~B + 1 (used by sub and slt)
    logic             sub, cout, ovf;
    logic [WIDTH-1:0] b_op, sum;

    assign sub  = (ALUControl == 3'b001) || (ALUControl == 3'b101);
    assign b_op = sub ? ~SrcB : SrcB;
    assign {cout, sum} = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    assign ovf  = (SrcA[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);

    // Result select; unsupported codes yield an all-zero result with clear C/V
    always_comb begin
        calc = '0;
        unique case (ALUControl)
            3'b000, 3'b001: begin
                calc.res = sum;
                calc.c   = cout;
                calc.v   = ovf;
            end
            3'b010: calc.res = SrcA & SrcB;
            3'b011: calc.res = SrcA | SrcB;
            3'b101: begin
                calc.res[0] = sum[WIDTH-1] ^ ovf;
                calc.c      = cout;
                calc.v      = ovf;
            end
            default: calc.res = '0;
        endcase
        calc.z = (calc.res == '0);
        calc.n = calc.res[WIDTH-1];
    end

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Buffer occupancy state register; in_ready is registered from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next;
            in_ready <= (next != TWO);
        end
    end

    // Next-state and register load selects
    always_comb begin
        next        = state;
        load_m_new  = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    next       = ONE;
                    load_m_new = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_m_new = 1'b1;
                end else if (accept) begin
                    next   = TWO;
                    load_s = 1'b1;
                end else if (pop) begin
                    next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    next        = ONE;
                    load_m_skid = 1'b1;
                end
            end
            default: next = EMPTY;
        endcase
    end

    // Main and skid data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m_new)       m_q <= calc;
            else if (load_m_skid) m_q <= s_q;
            if (load_s)           s_q <= calc;
        end
    end

    assign out_valid = (state != EMPTY);
    assign ALUResult = m_q.res;
    assign Zero      = m_q.z;
    assign Negative  = m_q.n;
    assign Carry     = m_q.c;
    assign Overflow  = m_q.v;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized scoreboard bench for alu_exec_stage: a reference model built
// from plain integer arithmetic predicts each result when it is accepted.
module tb_alu_exec_stage;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [2:0]   ALUControl = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALUResult;
    logic         Zero, Negative, Carry, Overflow;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Negative(Negative),
        .Carry(Carry), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, independent of adder form
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
        exp_t   e;
        longint sa, sbv, sr;
        e  = '0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            3'd0: begin
                e.res = a + b;
                e.c   = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                sr    = sa + sbv;
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1, 3'd5: begin
                sr    = sa - sbv;
                e.c   = (a >= b);
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                e.res = (op == 3'd1) ? a - b : ((sa < sbv) ? 32'd1 : 32'd0);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            default: e.res = '0;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Input monitor: an op is accepted at the next rising edge
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            sb.push_back(model(SrcA, SrcB, ALUControl));
    end

    // Output monitor: compare popped results and check stability under stall
    exp_t prev;
    bit   hold = 0;
    always @(negedge clk) begin
        exp_t act, e;
        act = '{ALUResult, Zero, Negative, Carry, Overflow};
        if (rst) begin
            hold = 0;
        end else begin
            if (hold) chk("stall_stable", 64'(act), 64'(prev));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(act), 64'(e));
                end
            end
            hold = out_valid && !out_ready;
            prev = act;
        end
    end

    // Present one op; returns just after the edge that accepted it
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int n;
        SrcA = a; SrcB = b; ALUControl = op; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        longint t0;
        // Reset values
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(ALUResult), 64'd0);
        chk("rst_flags", 64'({Zero, Negative, Carry, Overflow}), 64'd0);
        @(posedge clk); #1;

        // Basic add with one-cycle latency
        out_ready = 1'b1;
        send(32'd5, 32'd3, 3'b000);
        @(negedge clk);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("add_5_3", 64'(ALUResult), 64'd8);
        chk("in_ready_hi", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed arithmetic corners
        send(32'h8000_0000, 32'h1, 3'b001);
        send(32'hFFFF_FFFF, 32'h1, 3'b000);
        send(32'hFFFF_FFFF, 32'h1, 3'b101);
        send(32'h7FFF_FFFF, 32'h8000_0000, 3'b101);
        send(32'h1234_5678, 32'h9, 3'b110);
        send(32'h1, 32'h1, 3'b100);
        send(32'h1, 32'h1, 3'b111);
        idle(3);
        chk("drain_directed", 64'(sb.size()), 64'd0);

        // Backpressure: third op must wait upstream
        out_ready = 1'b0;
        fork
            begin
                send(32'hF0F0, 32'hFF00, 3'b010);
                send(32'h0F, 32'hF0, 3'b011);
                send(32'd1, 32'd1, 3'b000);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_head", 64'(ALUResult), 64'hF000);
                chk("bp_pending", 64'(sb.size()), 64'd2);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("drain_bp", 64'(sb.size()), 64'd0);

        // Full throughput, random ops including unsupported codes
        t0 = $time;
        for (int i = 0; i < 100; i++)
            send($urandom, (i % 4 == 0) ? $urandom_range(3, 0) : $urandom, 3'($urandom_range(7, 0)));
        chk("throughput_cycles", 64'(($time - t0) / 10), 64'd100);
        idle(3);
        chk("drain_random", 64'(sb.size()), 64'd0);

        // Random backpressure mixed with random stimulus
        fork
            begin
                for (int i = 0; i < 60; i++) send($urandom, $urandom, 3'($urandom_range(7, 0)));
            end
            begin
                repeat (150) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(2, 0) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(4);
        chk("drain_mixed", 64'(sb.size()), 64'd0);

        // Reset while full: pending ops are discarded
        out_ready = 1'b0;
        send(32'h11, 32'h22, 3'b000);
        send(32'h33, 32'h44, 3'b000);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1; SrcA = 32'h5; SrcB = 32'h5; ALUControl = 3'b000;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_result", 64'(ALUResult), 64'd0);
        out_ready = 1'b1;
        idle(4);
        @(negedge clk);
        chk("rst2_no_ghost", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
